pipe_backend: RTL and testbench

PIPE_BACKEND -- requirements
Module: pipe_backend

---
 rtl/pipe_backend_pkg.sv | 51 +++++
 rtl/pipe_backend.sv | 149 ++++++++++++++
 tb/tb_pipe_backend.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_backend_pkg.sv
// Shared pipe bundle definitions and field-offset helpers.
// Bundle layout (LSB first): ready, valid, data[DataW], then start, stop
// when the spec carries framing flags. Spec word: bits [7:0] data width,
// bit 8 start/stop present.
`ifndef PIPE_DEFS_SV
`define PIPE_DEFS_SV

`define PS_START_STOP 32'h100
`define P_Data_w(s) ((s) & 32'hFF)
`define P_HasSS(s) (((s) & `PS_START_STOP) != 32'd0)
`define P_w(s) (`P_Data_w(s) + 32'd2 + (`P_HasSS(s) ? 32'd2 : 32'd0))

package pipe_backend_pkg;

    localparam int unsigned PsStartStop = 32'h100;

    function automatic int unsigned p_data_w(input int unsigned spec);
        return spec & 32'hFF;
    endfunction

    function automatic bit p_has_ss(input int unsigned spec);
        return (spec & PsStartStop) != 32'd0;
    endfunction

    function automatic int unsigned p_w(input int unsigned spec);
        return p_data_w(spec) + 32'd2 + (p_has_ss(spec) ? 32'd2 : 32'd0);
    endfunction

    function automatic int unsigned p_pack_ready_lsb();
        return 32'd0;
    endfunction

    function automatic int unsigned p_pack_valid_lsb();
        return 32'd1;
    endfunction

    function automatic int unsigned p_pack_data_lsb();
        return 32'd2;
    endfunction

    function automatic int unsigned p_pack_start_lsb(input int unsigned spec);
        return 32'd2 + p_data_w(spec);
    endfunction

    function automatic int unsigned p_pack_stop_lsb(input int unsigned spec);
        return 32'd3 + p_data_w(spec);
    endfunction

endpackage

`endif

// File: rtl/pipe_backend.sv
// pipe_backend: two-register skid buffer driving a downstream pipe bundle.
// Ports:
//   clock, reset       - rising-edge clock, async active-high reset
//   pipe_out           - downstream bundle; ready driven by consumer, rest here
//   out_start/out_stop - framing flags of the offered word (unused without start/stop)
//   out_data           - offered word
//   out_valid          - producer offers a word
//   out_ready          - word accepted this cycle (state != SKID, not in reset)
`ifndef PIPE_DEFS_SV
`include "pipe_backend_pkg.sv"
`endif

module pipe_backend
    import pipe_backend_pkg::*;
#(
    parameter int unsigned PipeSpec = 8 | `PS_START_STOP
) (
    input  logic                               clock,
    input  logic                               reset,
    inout  wire  [`P_w(PipeSpec)-1:0]          pipe_out,
    input  logic                               out_start,
    input  logic                               out_stop,
    input  logic [`P_Data_w(PipeSpec)-1:0]     out_data,
    input  logic                               out_valid,
    output logic                               out_ready
);

    localparam int unsigned DataW    = `P_Data_w(PipeSpec);
    localparam bit          HasSs    = p_has_ss(PipeSpec);
    localparam int unsigned ReadyLsb = p_pack_ready_lsb();
    localparam int unsigned ValidLsb = p_pack_valid_lsb();
    localparam int unsigned DataLsb  = p_pack_data_lsb();
    localparam int unsigned StartLsb = p_pack_start_lsb(PipeSpec);
    localparam int unsigned StopLsb  = p_pack_stop_lsb(PipeSpec);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               main_start;
    logic               main_stop;
    logic [DataW-1:0]   main_data;
    logic               skid_start;
    logic               skid_stop;
    logic [DataW-1:0]   skid_data;
    logic               load_main;
    logic               main_from_skid;
    logic               load_skid;
    logic               ready;
    logic               in_xfer;
    logic               out_xfer;

    // Handshake decode; out_ready depends only on state and reset.
    assign ready     = pipe_out[ReadyLsb];
    assign out_ready = (state != SKID) & ~reset;
    assign in_xfer   = out_valid & out_ready;
    assign out_xfer  = (state != EMPTY) & ready;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state and register load enables.
    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    load_main  = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    // Main must stay stable while stalled, so park the new word.
                    load_skid  = 1'b1;
                    state_next = SKID;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end
            end
            SKID: begin
                if (out_xfer) begin
                    main_from_skid = 1'b1;
                    state_next     = HOLD;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Word registers; main is held (not cleared) when the pipe drains.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_start <= 1'b0;
            main_stop  <= 1'b0;
            main_data  <= '0;
            skid_start <= 1'b0;
            skid_stop  <= 1'b0;
            skid_data  <= '0;
        end else begin
            if (load_main) begin
                main_start <= out_start;
                main_stop  <= out_stop;
                main_data  <= out_data;
            end else if (main_from_skid) begin
                main_start <= skid_start;
                main_stop  <= skid_stop;
                main_data  <= skid_data;
            end
            if (load_skid) begin
                skid_start <= out_start;
                skid_stop  <= out_stop;
                skid_data  <= out_data;
            end
        end
    end

    assign pipe_out[ValidLsb]            = (state != EMPTY);
    assign pipe_out[DataLsb +: DataW]    = main_data;

    // Framing fields exist on the bundle only when the spec carries them.
    generate
        if (HasSs) begin : g_ss
            assign pipe_out[StartLsb] = main_start;
            assign pipe_out[StopLsb]  = main_stop;
        end else begin : g_no_ss
            logic unused_ss;
            assign unused_ss = ^{main_start, main_stop};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_backend.sv
// Self-checking bench for pipe_backend: a 2-entry FIFO reference model
// (head word shown on the pipe, last head held when empty) compared every
// negedge, directed scenarios with literal expectations, then random traffic.
module tb_pipe_backend;
    import pipe_backend_pkg::*;

    localparam int unsigned Spec = 32'd8 | 32'h100;
    localparam int unsigned Pw   = p_w(Spec);
    localparam int unsigned VLsb = p_pack_valid_lsb();
    localparam int unsigned RLsb = p_pack_ready_lsb();
    localparam int unsigned DLsb = p_pack_data_lsb();
    localparam int unsigned SLsb = p_pack_start_lsb(Spec);
    localparam int unsigned TLsb = p_pack_stop_lsb(Spec);

    logic          clock = 1'b0;
    logic          reset;
    logic          ready;
    logic          out_start;
    logic          out_stop;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    wire  [Pw-1:0] pipe;
    wire           p_valid;
    wire  [9:0]    p_word;

    assign pipe[RLsb] = ready;
    assign p_valid    = pipe[VLsb];
    assign p_word     = {pipe[SLsb], pipe[TLsb], pipe[DLsb +: 8]};

    pipe_backend #(.PipeSpec(Spec)) dut (
        .clock     (clock),
        .reset     (reset),
        .pipe_out  (pipe),
        .out_start (out_start),
        .out_stop  (out_stop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words {start,stop,data}, up to two held.
    logic [9:0] q[$];
    logic [9:0] log_q[$];
    logic [9:0] last = 10'h0;
    int         n_pushed = 0;
    bit         m_in;
    bit         m_out;

    always @(posedge clock) begin
        if (!reset) begin
            m_out = ready && (q.size() > 0);
            m_in  = out_valid && (q.size() < 2);
            if (m_out) log_q.push_back(q.pop_front());
            if (m_in) begin
                q.push_back({out_start, out_stop, out_data});
                n_pushed++;
            end
            if (q.size() > 0) last = q[0];
        end
    end

    // Compare DUT against model mid-cycle.
    always @(negedge clock) begin
        chk("pipe_valid", 32'(p_valid), 32'(q.size() > 0));
        chk("out_ready", 32'(out_ready), 32'(!reset && (q.size() < 2)));
        chk("pipe_word", 32'(p_word), 32'((q.size() > 0) ? q[0] : last));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic s, input logic t, input logic [7:0] d);
        out_valid = 1'b1;
        out_start = s;
        out_stop  = t;
        out_data  = d;
    endtask

    task automatic idle();
        out_valid = 1'b0;
        out_start = 1'b0;
        out_stop  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [7:0] tv[3];
        bit acc;
        reset = 1'b1;
        ready = 1'b0;
        out_data = 8'h00;
        idle();
        repeat (3) step();
        chk("rst_out_ready", 32'(out_ready), 32'd0);
        chk("rst_valid", 32'(p_valid), 32'd0);
        chk("rst_word", 32'(p_word), 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_ready", 32'(out_ready), 32'd1);

        // Pass-through.
        log_q.delete();
        ready = 1'b1;
        offer(1'b1, 1'b0, 8'h55);
        chk("pt_accept", 32'(out_ready), 32'd1);
        step();
        idle();
        chk("pt_valid", 32'(p_valid), 32'd1);
        chk("pt_word", 32'(p_word), 32'h255);
        step();
        chk("pt_drain_valid", 32'(p_valid), 32'd0);
        chk("pt_held_data", 32'(p_word[7:0]), 32'h55);
        chk("pt_log", 32'(log_q.size()), 32'd1);

        // Stall into skid.
        log_q.delete();
        ready = 1'b0;
        offer(1'b0, 1'b0, 8'h45);
        step();
        offer(1'b0, 1'b0, 8'h46);
        step();
        idle();
        chk("sk_out_ready", 32'(out_ready), 32'd0);
        chk("sk_word", 32'(p_word), 32'h045);
        step();
        chk("sk_stable", 32'(p_word), 32'h045);
        ready = 1'b1;
        step();
        chk("sk_second", 32'(p_word), 32'h046);
        step();
        chk("sk_empty", 32'(p_valid), 32'd0);
        chk("sk_log_n", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("sk_log0", 32'(log_q[0]), 32'h045);
            chk("sk_log1", 32'(log_q[1]), 32'h046);
        end

        // Streaming 0x01..0x10.
        log_q.delete();
        for (int i = 1; i <= 16; i++) begin
            offer(1'b0, 1'b0, 8'(i));
            chk("st_ready", 32'(out_ready), 32'd1);
            step();
        end
        idle();
        step();
        chk("st_log_n", 32'(log_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < log_q.size(); i++)
            chk("st_order", 32'(log_q[i]), 32'(i + 1));

        // Ready toggling.
        log_q.delete();
        tv[0] = 8'hAA; tv[1] = 8'h0A; tv[2] = 8'hA0;
        k = 0;
        for (int c = 0; c < 40 && k < 3; c++) begin
            offer(1'b0, 1'b0, tv[k]);
            acc = out_ready;
            step();
            if (acc) k++;
            ready = ~ready;
        end
        idle();
        ready = 1'b1;
        repeat (3) step();
        chk("tg_log_n", 32'(log_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_q.size(); i++)
            chk("tg_order", 32'(log_q[i]), 32'(tv[i]));

        // Reset while in SKID, consumer ready.
        log_q.delete();
        ready = 1'b0;
        offer(1'b0, 1'b0, 8'h11);
        step();
        offer(1'b0, 1'b0, 8'h22);
        step();
        idle();
        chk("mr_skid", 32'(out_ready), 32'd0);
        ready = 1'b1;
        reset = 1'b1;
        q.delete();
        last = 10'h0;
        #1;
        chk("mr_valid_now", 32'(p_valid), 32'd0);
        chk("mr_ready_now", 32'(out_ready), 32'd0);
        chk("mr_data_now", 32'(p_word), 32'd0);
        #2;
        reset = 1'b0;
        step();
        chk("mr_post_ready", 32'(out_ready), 32'd1);
        step();
        chk("mr_no_deliver", 32'(log_q.size()), 32'd0);

        // Framing flags travel with their word.
        log_q.delete();
        offer(1'b1, 1'b0, 8'hA1); step();
        offer(1'b0, 1'b0, 8'hA2); step();
        offer(1'b0, 1'b1, 8'hA3); step();
        idle();
        step();
        chk("fr_log_n", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("fr_w0", 32'(log_q[0]), 32'h2A1);
            chk("fr_w1", 32'(log_q[1]), 32'h0A2);
            chk("fr_w2", 32'(log_q[2]), 32'h1A3);
        end

        // Random traffic against the model.
        log_q.delete();
        n_pushed = 0;
        for (int c = 0; c < 3000; c++) begin
            out_valid = ($urandom_range(0, 3) != 0);
            out_start = 1'($urandom);
            out_stop  = 1'($urandom);
            out_data  = 8'($urandom);
            ready     = ($urandom_range(0, 2) != 0);
            step();
        end
        idle();
        ready = 1'b1;
        repeat (4) step();
        chk("rnd_conserve", 32'(log_q.size()), 32'(n_pushed));
        chk("rnd_drained", 32'(p_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
